// File: rtl/jk_drive_ctrl_if.sv
// Request/drive/feedback bundle between a JK-bank controller and its client.
// The slave side is the controller; the master side issues requests and owns the bank.
interface jk_drive_ctrl_if #(
   parameter int WIDTH = 8
);
   logic             tgt_valid;
   logic             tgt_ready;
   logic [1:0]       tgt_mode;
   logic [WIDTH-1:0] tgt_data;
   logic [WIDTH-1:0] q_fb;
   logic [WIDTH-1:0] j;
   logic [WIDTH-1:0] k;
   logic             busy;
   logic             done;
   logic             err;
   logic [WIDTH-1:0] err_bits;

   modport slave (
      input  tgt_valid, tgt_mode, tgt_data, q_fb,
      output tgt_ready, j, k, busy, done, err, err_bits
   );

   modport master (
      output tgt_valid, tgt_mode, tgt_data, q_fb,
      input  tgt_ready, j, k, busy, done, err, err_bits
   );
endinterface

// File: rtl/jk_drive_ctrl.sv
// Drives a WIDTH-bit JK flip-flop bank to a requested value, verifies via q_fb, retries up to MAX_RETRY.
// Optional JK_STICKY_ERR_EN: err stays high from the failing check until the next accepted request.
module jk_drive_ctrl #(
   parameter int WIDTH     = 8,
   parameter int MAX_RETRY = 3
) (
   input  logic            clk,
   input  logic            rst,
   jk_drive_ctrl_if.slave  bus
);
   localparam int            RW   = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
   localparam logic [RW-1:0] RMAX = RW'(MAX_RETRY);

   typedef enum logic [1:0] {IDLE, DRIVE, CHECK} state_t;

   localparam logic [1:0] M_LOAD   = 2'b00;
   localparam logic [1:0] M_TOGGLE = 2'b01;
   localparam logic [1:0] M_CLEAR  = 2'b10;

   state_t           state, state_n;
   logic [WIDTH-1:0] tgt, tgt_n, t_new;
   logic [RW-1:0]    retry, retry_n;
   logic [WIDTH-1:0] j_r, j_n, k_r, k_n;
   logic             done_r, done_n, err_r, err_n;
   logic [WIDTH-1:0] err_bits_r, err_bits_n;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state      <= IDLE;
         tgt        <= '0;
         retry      <= '0;
         j_r        <= '0;
         k_r        <= '0;
         done_r     <= 1'b0;
         err_r      <= 1'b0;
         err_bits_r <= '0;
      end else begin
         state      <= state_n;
         tgt        <= tgt_n;
         retry      <= retry_n;
         j_r        <= j_n;
         k_r        <= k_n;
         done_r     <= done_n;
         err_r      <= err_n;
         err_bits_r <= err_bits_n;
      end
   end

   // j/k are derived per bit from the target and current Q, so they can never both be set.
   always_comb begin
      state_n    = state;
      tgt_n      = tgt;
      retry_n    = retry;
      j_n        = '0;
      k_n        = '0;
      done_n     = 1'b0;
`ifdef JK_STICKY_ERR_EN
      err_n      = err_r;
`else
      err_n      = 1'b0;
`endif
      err_bits_n = err_bits_r;
      t_new      = bus.q_fb;
      case (state)
         IDLE: begin
            if (bus.tgt_valid) begin
               case (bus.tgt_mode)
                  M_LOAD:   t_new = bus.tgt_data;
                  M_TOGGLE: t_new = bus.q_fb ^ bus.tgt_data;
                  M_CLEAR:  t_new = '0;
                  default:  t_new = bus.q_fb;
               endcase
               tgt_n   = t_new;
               retry_n = '0;
               j_n     = t_new & ~bus.q_fb;
               k_n     = ~t_new & bus.q_fb;
               state_n = DRIVE;
               err_n   = 1'b0;
            end
         end
         DRIVE: state_n = CHECK;
         CHECK: begin
            if (bus.q_fb == tgt) begin
               state_n = IDLE;
               done_n  = 1'b1;
            end else if (retry < RMAX) begin
               retry_n = retry + 1'b1;
               j_n     = tgt & ~bus.q_fb;
               k_n     = ~tgt & bus.q_fb;
               state_n = DRIVE;
            end else begin
               state_n    = IDLE;
               err_n      = 1'b1;
               err_bits_n = bus.q_fb ^ tgt;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   assign bus.tgt_ready = (state == IDLE);
   assign bus.busy      = (state != IDLE);
   assign bus.j         = j_r;
   assign bus.k         = k_r;
   assign bus.done      = done_r;
   assign bus.err       = err_r;
   assign bus.err_bits  = err_bits_r;
endmodule
